sdram_init_sequencer: RTL and testbench

SDRAM_INIT_SEQUENCER -- requirements
Module: sdram_init_sequencer

---
 rtl/sdram_pkg.sv | 42 ++++
 rtl/sdram_wait_timer.sv | 24 ++
 rtl/sdram_init_sequencer.sv | 128 ++++++++++++
 tb/tb_sdram_init_sequencer.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, init-sequencer state type and timing helpers.
package sdram_pkg;

  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0] CMD_NOP          = 4'b0111;
  localparam logic [3:0] CMD_PRECHARGE    = 4'b0010;
  localparam logic [3:0] CMD_AUTO_REFRESH = 4'b0001;
  localparam logic [3:0] CMD_LOAD_MODE    = 4'b0000;
  localparam logic [3:0] CMD_DESELECT     = 4'b1111;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_WAIT_PWR,
    ST_PRECHARGE,
    ST_WAIT_RP,
    ST_REFRESH,
    ST_WAIT_RFC,
    ST_LOAD_MODE,
    ST_WAIT_MRD,
    ST_DONE
  } state_t;

  // ceil(t_ns * clk_hz / 1e9), never below one clock
  function automatic int unsigned ns_to_cycles(real t_ns, real clk_hz);
    real         cyc;
    int unsigned n;
    // small bias keeps exact multiples (e.g. 20 ns at 100 MHz) from rounding up on float noise
    cyc = t_ns * 1.0e-9 * clk_hz - 1.0e-6;
    if (cyc <= 0.0) return 1;
    n = $rtoi(cyc);
    if ($itor(n) < cyc) n = n + 1;
    if (n < 1) n = 1;
    return n;
  endfunction

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/sdram_wait_timer.sv
// Down-counting spacing timer: start loads a count, expired pulses on the last waited cycle.
module sdram_wait_timer #(
  parameter int unsigned W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         start,
  input  logic [W-1:0] load,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (clr)         cnt <= '0;
    else if (start)       cnt <= load;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == W'(1));

endmodule

// File: rtl/sdram_init_sequencer.sv
// SDRAM power-up sequencer: PRECHARGE ALL, N x AUTO_REFRESH, LOAD_MODE, then init_done.
module sdram_init_sequencer
  import sdram_pkg::*;
#(
  parameter real         CLK           = 111857000.0,
  parameter real         T_RP_NS       = 20.0,
  parameter real         T_RFC_NS      = 70.0,
  parameter int unsigned T_MRD_CYC     = 2,
  parameter int unsigned REFRESH_COUNT = 8,
  parameter logic [10:0] MODE_REG      = 11'h020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sdram_init_n,
  output logic        sdram_cke,
  output logic        sdram_cs_n,
  output logic        sdram_ras_n,
  output logic        sdram_cas_n,
  output logic        sdram_we_n,
  output logic [10:0] sdram_addr,
  output logic [1:0]  sdram_ba,
  output logic        init_done
);

  localparam int unsigned C_RP  = ns_to_cycles(T_RP_NS, CLK);
  localparam int unsigned C_RFC = ns_to_cycles(T_RFC_NS, CLK);
  localparam int unsigned C_MRD = (T_MRD_CYC < 1) ? 1 : T_MRD_CYC;
  localparam int unsigned TW    = $clog2(max3(C_RP, C_RFC, C_MRD) + 1);

  state_t          state, next_state;
  logic [3:0]      ref_cnt;
  logic            tmr_clr, tmr_start, tmr_expired;
  logic [TW-1:0]   tmr_load;
  logic            cke_d, done_d;
  logic [3:0]      cmd_d;
  logic [10:0]     addr_d;

  // The command state itself accounts for one clock of spacing, so the timer waits C-1.
  always_comb begin
    tmr_load  = '0;
    tmr_start = 1'b0;
    case (state)
      ST_PRECHARGE: begin tmr_start = 1'b1; tmr_load = TW'(C_RP - 1);  end
      ST_REFRESH:   begin tmr_start = 1'b1; tmr_load = TW'(C_RFC - 1); end
      ST_LOAD_MODE: begin tmr_start = 1'b1; tmr_load = TW'(C_MRD - 1); end
      default:      ;
    endcase
  end

  assign tmr_clr = (next_state == ST_WAIT_PWR) || (next_state == ST_IDLE);

  sdram_wait_timer #(.W(TW)) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clr     (tmr_clr),
    .start   (tmr_start),
    .load    (tmr_load),
    .expired (tmr_expired)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               ref_cnt <= '0;
    else if (tmr_clr)                      ref_cnt <= '0;
    else if (state == ST_REFRESH && ref_cnt != '1) ref_cnt <= ref_cnt + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    if (state != ST_IDLE && state != ST_WAIT_PWR && !sdram_init_n) begin
      next_state = ST_WAIT_PWR;
    end else begin
      case (state)
        ST_IDLE:      if (!sdram_init_n) next_state = ST_WAIT_PWR;
        ST_WAIT_PWR:  if (sdram_init_n)  next_state = ST_PRECHARGE;
        ST_PRECHARGE: next_state = (C_RP > 1) ? ST_WAIT_RP : ST_REFRESH;
        ST_WAIT_RP:   if (tmr_expired) next_state = ST_REFRESH;
        ST_REFRESH: begin
          if (C_RFC > 1)                                next_state = ST_WAIT_RFC;
          else if (ref_cnt == 4'(REFRESH_COUNT - 1))    next_state = ST_LOAD_MODE;
        end
        ST_WAIT_RFC:
          if (tmr_expired)
            next_state = (ref_cnt == 4'(REFRESH_COUNT)) ? ST_LOAD_MODE : ST_REFRESH;
        ST_LOAD_MODE: next_state = (C_MRD > 1) ? ST_WAIT_MRD : ST_DONE;
        ST_WAIT_MRD:  if (tmr_expired) next_state = ST_DONE;
        ST_DONE:      next_state = ST_DONE;
        default:      next_state = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    cke_d  = 1'b1;
    cmd_d  = CMD_NOP;
    addr_d = '0;
    done_d = 1'b0;
    case (state)
      ST_IDLE:      begin cke_d = 1'b0; cmd_d = CMD_DESELECT; end
      ST_PRECHARGE: begin cmd_d = CMD_PRECHARGE; addr_d = 11'h400; end
      ST_REFRESH:   cmd_d = CMD_AUTO_REFRESH;
      ST_LOAD_MODE: begin cmd_d = CMD_LOAD_MODE; addr_d = MODE_REG; end
      ST_DONE:      done_d = 1'b1;
      default:      ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdram_cke  <= 1'b0;
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= CMD_DESELECT;
      sdram_addr <= '0;
      sdram_ba   <= '0;
      init_done  <= 1'b0;
    end else begin
      sdram_cke  <= cke_d;
      {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} <= cmd_d;
      sdram_addr <= addr_d;
      sdram_ba   <= '0;
      init_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_sdram_init_sequencer.sv
// Randomized check of the SDRAM init sequencer against a schedule-based reference model.
module tb_sdram_init_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_a, init_b;
  logic        cke_a, cs_a, ras_a, cas_a, we_a, done_a;
  logic        cke_b, cs_b, ras_b, cas_b, we_b, done_b;
  logic [10:0] addr_a, addr_b;
  logic [1:0]  ba_a, ba_b;
  logic [18:0] obs_a, obs_b;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [18:0] EXP_IDLE = {1'b0, 4'b1111, 11'h000, 2'b00, 1'b0};
  localparam logic [18:0] EXP_WAIT = {1'b1, 4'b0111, 11'h000, 2'b00, 1'b0};

  always #5 clk = ~clk;

  sdram_init_sequencer #(
    .CLK(100.0e6), .T_RP_NS(20.0), .T_RFC_NS(70.0),
    .T_MRD_CYC(2), .REFRESH_COUNT(8), .MODE_REG(11'h020)
  ) dut (
    .clk(clk), .rst(rst), .sdram_init_n(init_a),
    .sdram_cke(cke_a), .sdram_cs_n(cs_a), .sdram_ras_n(ras_a),
    .sdram_cas_n(cas_a), .sdram_we_n(we_a), .sdram_addr(addr_a),
    .sdram_ba(ba_a), .init_done(done_a)
  );

  sdram_init_sequencer #(
    .CLK(100.0e6), .T_RP_NS(1.0), .T_RFC_NS(70.0),
    .T_MRD_CYC(2), .REFRESH_COUNT(1), .MODE_REG(11'h020)
  ) dut_b (
    .clk(clk), .rst(rst), .sdram_init_n(init_b),
    .sdram_cke(cke_b), .sdram_cs_n(cs_b), .sdram_ras_n(ras_b),
    .sdram_cas_n(cas_b), .sdram_we_n(we_b), .sdram_addr(addr_b),
    .sdram_ba(ba_b), .init_done(done_b)
  );

  assign obs_a = {cke_a, cs_a, ras_a, cas_a, we_a, addr_a, ba_a, done_a};
  assign obs_b = {cke_b, cs_b, ras_b, cas_b, we_b, addr_b, ba_b, done_b};

  task automatic check_vec(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Expected outputs k clocks after the edge that first samples init_n high.
  function automatic logic [18:0] exp_out(int k, int rp, int rfc, int mrd, int rc);
    logic [3:0]  cmd;
    logic [10:0] addr;
    int          lm;
    cmd  = 4'b0111;
    addr = 11'h000;
    lm   = 1 + rp + rc * rfc;
    if (k == 1) begin cmd = 4'b0010; addr = 11'h400; end
    for (int i = 0; i < rc; i++)
      if (k == 1 + rp + i * rfc) cmd = 4'b0001;
    if (k == lm) begin cmd = 4'b0000; addr = 11'h020; end
    return {1'b1, cmd, addr, 2'b00, (k >= lm + mrd)};
  endfunction

  function automatic logic [18:0] pick(input bit b);
    return b ? obs_b : obs_a;
  endfunction

  // Hold init_n low n clocks; from the second clock on the device must be in NOP wait.
  task automatic low_phase(input bit b, input int n);
    if (b) init_b = 1'b0; else init_a = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i >= 1) check_vec("pwr_wait", pick(b), EXP_WAIT);
    end
    if (b) init_b = 1'b1; else init_a = 1'b1;
  endtask

  task automatic run_seq(input bit b, input int rp, input int rfc, input int mrd,
                         input int rc, input int stop_at, input bit do_abort);
    int last, refs;
    last = 1 + rp + rc * rfc + mrd + 3;
    refs = 0;
    for (int k = 0; k <= last; k++) begin
      @(negedge clk);
      check_vec("seq", pick(b), exp_out(k, rp, rfc, mrd, rc));
      if (pick(b)[17:14] == 4'b0001) refs++;
      if (k == stop_at) begin
        if (do_abort) begin
          if (b) init_b = 1'b0; else init_a = 1'b0;
          @(negedge clk);
          check_vec("abort_pre", pick(b), exp_out(k + 1, rp, rfc, mrd, rc));
          @(negedge clk);
          check_vec("abort_nop", pick(b), EXP_WAIT);
        end
        return;
      end
    end
    check_vec("refresh_count", 19'(refs), 19'(rc));
  endtask

  // Command spacing monitor for the main instance.
  int  gap = 0;
  int  req = 0;
  bit  have_prev = 1'b0;
  always @(negedge clk) begin
    gap++;
    if (rst || !init_a) begin
      have_prev = 1'b0;
    end else if (obs_a[17:14] != 4'b0111 && obs_a[17:14] != 4'b1111) begin
      if (have_prev) check_vec("spacing", {18'b0, (gap >= req)}, 19'd1);
      case (obs_a[17:14])
        4'b0010: req = 2;
        4'b0001: req = 7;
        default: req = 2;
      endcase
      gap = 0;
      have_prev = 1'b1;
    end
  end

  initial begin
    int a;
    rst = 1'b1; init_a = 1'b1; init_b = 1'b1;
    repeat (3) @(negedge clk);
    check_vec("reset_a", obs_a, EXP_IDLE);
    check_vec("reset_b", obs_b, EXP_IDLE);
    rst = 1'b0;

    // init_n already high out of reset must not start anything
    repeat (5) begin
      @(negedge clk);
      check_vec("idle_high", obs_a, EXP_IDLE);
    end

    low_phase(0, 10);
    run_seq(0, 2, 7, 2, 8, -1, 1'b0);

    // aborts: right after LOAD_MODE first, then random points
    for (int it = 0; it < 4; it++) begin
      a = (it == 0) ? 59 : int'($urandom_range(1, 62));
      low_phase(0, int'($urandom_range(2, 12)));
      run_seq(0, 2, 7, 2, 8, a, 1'b1);
      low_phase(0, int'($urandom_range(2, 6)));
      run_seq(0, 2, 7, 2, 8, -1, 1'b0);
    end

    // asynchronous reset while refresh #4 is on the pins
    low_phase(0, int'($urandom_range(2, 12)));
    run_seq(0, 2, 7, 2, 8, 24, 1'b0);
    #2 rst = 1'b1;
    #1 check_vec("async_reset", obs_a, EXP_IDLE);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check_vec("post_reset_idle", obs_a, EXP_IDLE);
    end
    low_phase(0, int'($urandom_range(2, 12)));
    run_seq(0, 2, 7, 2, 8, -1, 1'b0);

    // single refresh, precharge spacing clamped to one clock
    check_vec("b_idle", obs_b, EXP_IDLE);
    low_phase(1, int'($urandom_range(2, 8)));
    run_seq(1, 1, 7, 2, 1, -1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
